mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Single-port memory arbiter and sequencer for the 5-stage RV32I pipeline. Shares one unified instruction/data memory port between the IF-stage fetch and the MEM-stage load/store. Drives the request/response handshake to memory and produces the IF and MEM stall signals consumed by the pipeline control alongside the hazard unit. Discards fetch responses invalidated by a taken branch or jump flush.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; the strobe width is `DATA_W/8`.

Ports (`name  direction  width  meaning`):
- `clk  in  1`: clock. One clock domain; reset is synchronous and active-low.
- `rst_n  in  1`: synchronous active-low reset.
- `if_req  in  1`: IF wants an instruction word.
- `if_addr  in  ADDR_W`: fetch address (PC).
- `if_rdata  out  DATA_W`: fetched instruction.
- `if_valid  out  1`: one-cycle pulse; `if_rdata` is valid.
- `flush  in  1`: branch/jump redirect (PCsel_EX). Invalidates any fetch in flight.
- `d_req  in  1`: MEM stage holds a load or store.
- `d_we  in  1`: 1 = store.
- `d_addr  in  ADDR_W`: data address.
- `d_wdata  in  DATA_W`: store data.
- `d_wstrb  in  DATA_W/8`: byte strobes.
- `d_rdata  out  DATA_W`: load data.
- `d_done  out  1`: one-cycle pulse; load data valid or store committed.
- `mem_req  out  1`: request to memory (registered).
- `mem_we  out  1`: write enable to memory (registered).
- `mem_addr  out  ADDR_W`: memory address (registered).
- `mem_wdata  out  DATA_W`: write data to memory (registered).
- `mem_wstrb  out  DATA_W/8`: byte strobes to memory (registered).
- `mem_ready  in  1`: memory accepts the request this cycle.
- `mem_rvalid  in  1`: read data valid.
- `mem_rdata  in  DATA_W`: read data.
- `stall_if  out  1`: hold PC and IF/ID.
- `stall_mem  out  1`: hold EX/MEM and all earlier stages.

## Operation
- FSM states: IDLE, REQ, WAIT.
- Registered state: `owner` (0 = IF, 1 = D) and `drop` (fetch invalidated).
- At most one transaction is outstanding.
- **IDLE**
  - If `d_req`: latch `d_addr`, `d_we`, `d_wdata`, `d_wstrb`; set `owner`=D; go to REQ. Data always wins, because the MEM-stage instruction is older.
  - Else if `if_req` and not `flush`: latch `if_addr`, `mem_we`=0; set `owner`=IF; go to REQ. A fetch requested in a flush cycle is not issued, because its PC is stale.
- **REQ**
  - `mem_req`=1, with address, data and strobes held stable until `mem_ready`.
  - A request is never withdrawn once asserted.
  - On `mem_ready`:
    - Store: pulse `d_done` in that same cycle, then go to IDLE.
    - Load or fetch: go to WAIT.
- **WAIT**
  - `mem_req`=0.
  - On `mem_rvalid`, go to IDLE and then:
    - `owner`=D: `d_done`=1 and `d_rdata`=`mem_rdata`.
    - `owner`=IF and not `drop`: `if_valid`=1 and `if_rdata`=`mem_rdata`.
    - `owner`=IF and `drop`: no pulse; the data is discarded.
- **drop flag**
  - Set when `flush`=1 while `owner`=IF in REQ or WAIT.
  - Also set on a flush in the `mem_rvalid` cycle itself: `if_valid` is suppressed in that cycle.
  - Cleared on return to IDLE.
  - A flush never affects a data transaction.
- **Stalls**
  - `stall_mem` = `d_req` & ~`d_done`.
  - `stall_if` = (`if_req` & ~`if_valid`) | `stall_mem`.
- `if_rdata` and `d_rdata` pass `mem_rdata` through combinationally. They are meaningful only in a valid/done cycle.
- There is no back-to-back issue: every transaction returns to IDLE for one cycle.

## Timing
- Reset values: state=IDLE; `owner`=0, `drop`=0; `mem_req`=0, `mem_we`=0; `mem_addr`, `mem_wdata`, `mem_wstrb`=0.
  - Combinational outputs at reset: `if_valid`=0, `d_done`=0, `stall_mem`=`d_req`, `stall_if`=`if_req`|`d_req`.
- Minimum load/fetch latency, with a zero-wait memory (`mem_ready` in the first REQ cycle, `mem_rvalid` on the next cycle):
  - Request sampled in IDLE at cycle 0.
  - `mem_req` high in cycle 1.
  - `if_valid`/`d_done` in cycle 2.
- Minimum store latency: `d_done` in cycle 1.
- Each wait state on `mem_ready` or `mem_rvalid` adds exactly one cycle.
- Simultaneous `if_req` and `d_req` in IDLE: data is issued; the fetch waits, stalled, and is issued in the first IDLE cycle after `d_done`.
- Reset asserted in any state: IDLE on the next edge. The in-flight transaction is abandoned and no done/valid pulse is produced. Memory is reset with the same `rst_n`.
- `mem_rvalid` or `mem_ready` arriving in IDLE is ignored.

## Test plan
- Zero-wait fetch: `if_req`=1, `if_addr`=0x100, `mem_ready`=1 at cycle 1, `mem_rvalid`=1 with rdata 0x00500093 at cycle 2 → `mem_req` high only in cycle 1; `if_valid`=1 with `if_rdata`=0x00500093 at cycle 2; `stall_if` high in cycles 0–1.
- Conflict: `if_req`=1 (0x104) and a load `d_req`=1 (0x2000) in the same cycle → `mem_addr`=0x2000 issued first; `d_done` precedes any fetch; the fetch of 0x104 is issued in the IDLE cycle after `d_done`; `stall_if` stays high throughout.
- Store with 2 wait states: `d_we`=1, `d_addr`=0x2004, `d_wstrb`=0011, `mem_ready` low for 2 cycles → `mem_addr`, `mem_wdata` and `mem_wstrb` stable for 3 REQ cycles; `d_done` in the `mem_ready` cycle; no `if_valid`.
- Flush during fetch WAIT: fetch 0x108, `flush`=1 before `mem_rvalid` → the rvalid is consumed with `if_valid`=0; the next fetch (0x200) issues normally and returns `if_valid`=1.
- Flush in the IDLE request cycle: `if_req`=1 and `flush`=1 → `mem_req` stays 0 next cycle; the fetch is issued the following cycle once `flush`=0.
- Reset mid-WAIT: `rst_n`=0 while a load is outstanding → next cycle state IDLE, `mem_req`=0, no `d_done`; a late `mem_rvalid` is ignored.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the 5-stage RV32I pipeline.
// Shares one instruction/data memory port between IF fetches and MEM loads/stores.
// A pending data access always wins over a fetch because the MEM-stage instruction is older.
// Fetches invalidated by a branch/jump flush are completed on the bus but not reported.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    input  logic                  flush,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    input  logic [DATA_W/8-1:0]   d_wstrb,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  d_done,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                drop_q, drop_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]   mem_wstrb_q, mem_wstrb_d;

    logic                store_commit;
    logic                rd_return;

    // Completion pulses: stores finish on acceptance, loads/fetches on read data return
    always_comb begin
        store_commit = (state_q == S_REQ) && mem_ready && mem_we_q;
        rd_return    = (state_q == S_WAIT) && mem_rvalid;
        d_done       = store_commit || (rd_return && (owner_q == OWNER_D));
        // A flush in the return cycle itself also kills the fetch result
        if_valid     = rd_return && (owner_q == OWNER_IF) && !drop_q && !flush;
        if_rdata     = mem_rdata;
        d_rdata      = mem_rdata;
        stall_mem    = d_req && !d_done;
        stall_if     = (if_req && !if_valid) || stall_mem;
        mem_req      = mem_req_q;
        mem_we       = mem_we_q;
        mem_addr     = mem_addr_q;
        mem_wdata    = mem_wdata_q;
        mem_wstrb    = mem_wstrb_q;
    end

    // Next-state logic for the IDLE/REQ/WAIT sequencer and its registered bus outputs
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        drop_d      = drop_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        unique case (state_q)
            S_IDLE: begin
                drop_d = 1'b0;
                if (d_req) begin
                    owner_d     = OWNER_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    state_d     = S_REQ;
                end else if (if_req && !flush) begin
                    // A fetch in a flush cycle carries a stale PC, so it is not issued
                    owner_d    = OWNER_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (flush && (owner_q == OWNER_IF)) begin
                    drop_d = 1'b1;
                end
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    drop_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (flush && (owner_q == OWNER_IF)) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                drop_d    = 1'b0;
            end
        endcase
    end

    // State and registered memory-side outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWNER_IF;
            drop_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            drop_q      <= drop_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: cycle-exact directed scenarios followed by a
// randomized run against a word-level memory model and an in-order CPU requester model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          flush;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [SW-1:0] d_wstrb;
    logic [DW-1:0] d_rdata;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [SW-1:0] mem_wstrb;
    logic          mem_ready;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;
    logic          stall_if;
    logic          stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .flush(flush),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
        .d_rdata(d_rdata), .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata),
        .stall_if(stall_if), .stall_mem(stall_mem)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge
    task automatic to_drive();
        @(posedge clk);
        #1;
    endtask

    task automatic to_sample();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; flush = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Random-phase models
    logic [31:0] phys [256];     // memory contents as seen through the DUT's bus
    logic [31:0] ref_mem [256];  // memory contents implied by committed CPU stores
    bit          rd_pend, deliver, abort;
    int          rv_cnt, rdy_cnt;
    logic [31:0] rd_addr_m;
    bit          d_act, d_st;
    logic [31:0] d_a, d_wd;
    logic [3:0]  d_ws;
    int          d_gap, d_age;
    bit          f_act;
    logic [31:0] f_a;
    int          f_age;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // ---------------- reset values ----------------
        idle_inputs();
        rst_n = 1'b0;
        d_req = 1'b1;
        to_drive();
        to_sample();
        check_eq("rst_mem_req", mem_req, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_mem_addr", mem_addr, 0);
        check_eq("rst_mem_wdata", mem_wdata, 0);
        check_eq("rst_mem_wstrb", mem_wstrb, 0);
        check_eq("rst_d_done", d_done, 0);
        check_eq("rst_if_valid", if_valid, 0);
        check_eq("rst_stall_mem_dreq", stall_mem, 1);
        check_eq("rst_stall_if_dreq", stall_if, 1);
        to_drive();
        d_req = 1'b0; if_req = 1'b1;
        to_sample();
        check_eq("rst_stall_mem_ifreq", stall_mem, 0);
        check_eq("rst_stall_if_ifreq", stall_if, 1);
        check_eq("rst_mem_req_hold", mem_req, 0);
        to_drive();
        idle_inputs(); rst_n = 1'b1;
        to_sample();

        // ---------------- zero-wait fetch ----------------
        to_drive(); if_req = 1'b1; if_addr = 32'h100;
        to_sample();
        check_eq("zf_c0_stall_if", stall_if, 1);
        check_eq("zf_c0_mem_req", mem_req, 0);
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("zf_c1_mem_req", mem_req, 1);
        check_eq("zf_c1_mem_addr", mem_addr, 32'h100);
        check_eq("zf_c1_mem_we", mem_we, 0);
        check_eq("zf_c1_stall_if", stall_if, 1);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00500093;
        to_sample();
        check_eq("zf_c2_mem_req", mem_req, 0);
        check_eq("zf_c2_if_valid", if_valid, 1);
        check_eq("zf_c2_if_rdata", if_rdata, 32'h00500093);
        check_eq("zf_c2_stall_if", stall_if, 0);
        to_drive(); if_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();
        check_eq("zf_c3_if_valid", if_valid, 0);
        check_eq("zf_c3_mem_req", mem_req, 0);

        // ---------------- conflict: load wins over fetch ----------------
        to_drive();
        if_req = 1'b1; if_addr = 32'h104;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2000;
        to_sample();
        check_eq("cf_c0_stall_mem", stall_mem, 1);
        check_eq("cf_c0_stall_if", stall_if, 1);
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("cf_c1_mem_req", mem_req, 1);
        check_eq("cf_c1_mem_addr", mem_addr, 32'h2000);
        check_eq("cf_c1_stall_if", stall_if, 1);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        to_sample();
        check_eq("cf_c2_d_done", d_done, 1);
        check_eq("cf_c2_d_rdata", d_rdata, 32'hDEADBEEF);
        check_eq("cf_c2_if_valid", if_valid, 0);
        check_eq("cf_c2_stall_mem", stall_mem, 0);
        check_eq("cf_c2_stall_if", stall_if, 1);
        to_drive(); d_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();
        check_eq("cf_c3_mem_req", mem_req, 0);
        check_eq("cf_c3_d_done", d_done, 0);
        check_eq("cf_c3_stall_if", stall_if, 1);
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("cf_c4_mem_req", mem_req, 1);
        check_eq("cf_c4_mem_addr", mem_addr, 32'h104);
        check_eq("cf_c4_stall_if", stall_if, 1);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h00000013;
        to_sample();
        check_eq("cf_c5_if_valid", if_valid, 1);
        check_eq("cf_c5_if_rdata", if_rdata, 32'h00000013);
        check_eq("cf_c5_stall_if", stall_if, 0);
        to_drive(); if_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();

        // ---------------- store with two wait states ----------------
        to_drive();
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2004; d_wdata = 32'hCAFE1234; d_wstrb = 4'b0011;
        to_sample();
        check_eq("st_c0_stall_mem", stall_mem, 1);
        check_eq("st_c0_d_done", d_done, 0);
        for (int i = 1; i <= 3; i++) begin
            to_drive();
            d_wdata = 32'h0;            // issued store data must stay latched
            mem_ready = (i == 3);
            to_sample();
            check_eq($sformatf("st_c%0d_mem_req", i), mem_req, 1);
            check_eq($sformatf("st_c%0d_mem_we", i), mem_we, 1);
            check_eq($sformatf("st_c%0d_mem_addr", i), mem_addr, 32'h2004);
            check_eq($sformatf("st_c%0d_mem_wdata", i), mem_wdata, 32'hCAFE1234);
            check_eq($sformatf("st_c%0d_mem_wstrb", i), mem_wstrb, 4'b0011);
            check_eq($sformatf("st_c%0d_d_done", i), d_done, (i == 3));
            check_eq($sformatf("st_c%0d_if_valid", i), if_valid, 0);
        end
        to_drive(); d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
        to_sample();
        check_eq("st_c4_mem_req", mem_req, 0);
        check_eq("st_c4_d_done", d_done, 0);

        // ---------------- flush during fetch WAIT ----------------
        to_drive(); if_req = 1'b1; if_addr = 32'h108;
        to_sample();
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("fw_c1_mem_addr", mem_addr, 32'h108);
        to_drive(); mem_ready = 1'b0; flush = 1'b1;
        to_sample();
        check_eq("fw_c2_if_valid", if_valid, 0);
        to_drive(); flush = 1'b0; if_addr = 32'h200; mem_rvalid = 1'b1; mem_rdata = 32'h11111111;
        to_sample();
        check_eq("fw_c3_if_valid_dropped", if_valid, 0);
        check_eq("fw_c3_stall_if", stall_if, 1);
        to_drive(); mem_rvalid = 1'b0;
        to_sample();
        check_eq("fw_c4_mem_req", mem_req, 0);
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("fw_c5_mem_req", mem_req, 1);
        check_eq("fw_c5_mem_addr", mem_addr, 32'h200);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h22222222;
        to_sample();
        check_eq("fw_c6_if_valid", if_valid, 1);
        check_eq("fw_c6_if_rdata", if_rdata, 32'h22222222);
        to_drive(); if_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();

        // ---------------- flush in the rvalid cycle, then drop must clear ----------------
        to_drive(); if_req = 1'b1; if_addr = 32'h10C;
        to_sample();
        to_drive(); mem_ready = 1'b1;
        to_sample();
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h33333333; flush = 1'b1;
        to_sample();
        check_eq("fr_c2_if_valid", if_valid, 0);
        to_drive(); mem_rvalid = 1'b0; flush = 1'b0; if_req = 1'b0;
        to_sample();
        check_eq("fr_c3_mem_req", mem_req, 0);
        to_drive(); if_req = 1'b1; if_addr = 32'h110;
        to_sample();
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("fr_c5_mem_addr", mem_addr, 32'h110);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h44444444;
        to_sample();
        check_eq("fr_c6_if_valid", if_valid, 1);
        to_drive(); if_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();

        // ---------------- flush in the IDLE request cycle ----------------
        to_drive(); if_req = 1'b1; if_addr = 32'h300; flush = 1'b1;
        to_sample();
        check_eq("fi_c0_if_valid", if_valid, 0);
        to_drive(); flush = 1'b0;
        to_sample();
        check_eq("fi_c1_mem_req", mem_req, 0);
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("fi_c2_mem_req", mem_req, 1);
        check_eq("fi_c2_mem_addr", mem_addr, 32'h300);
        to_drive(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55555555;
        to_sample();
        check_eq("fi_c3_if_valid", if_valid, 1);
        to_drive(); if_req = 1'b0; mem_rvalid = 1'b0;
        to_sample();

        // ---------------- reset mid-WAIT ----------------
        to_drive(); d_req = 1'b1; d_we = 1'b0; d_addr = 32'h2008;
        to_sample();
        to_drive(); mem_ready = 1'b1;
        to_sample();
        check_eq("rw_c1_mem_req", mem_req, 1);
        to_drive(); mem_ready = 1'b0; rst_n = 1'b0;
        to_sample();
        check_eq("rw_c2_d_done", d_done, 0);
        to_drive(); rst_n = 1'b1; d_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h66666666;
        to_sample();
        check_eq("rw_c3_mem_req", mem_req, 0);
        check_eq("rw_c3_d_done", d_done, 0);
        check_eq("rw_c3_if_valid", if_valid, 0);
        to_drive(); mem_rvalid = 1'b0; mem_ready = 1'b1;
        to_sample();
        check_eq("rw_c4_mem_req", mem_req, 0);
        to_drive(); mem_ready = 1'b0;
        to_sample();
        check_eq("rw_c5_mem_req", mem_req, 0);
        check_eq("rw_c5_d_done", d_done, 0);

        // ---------------- randomized traffic ----------------
        to_drive(); idle_inputs(); rst_n = 1'b0;
        to_drive(); rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            phys[i] = $urandom;
            ref_mem[i] = phys[i];
        end
        rd_pend = 0; rv_cnt = 0; rdy_cnt = $urandom_range(0, 2); abort = 0;
        d_act = 0; d_st = 0; d_a = 32'h100; d_wd = 0; d_ws = 0; d_gap = 0; d_age = 0;
        f_act = 0; f_a = {24'd0, 6'($urandom_range(0, 63)), 2'b00}; f_age = 0;

        for (int cyc = 0; cyc < 4000 && !abort; cyc++) begin
            to_drive();
            // memory responder
            deliver = 0;
            mem_rvalid = 1'b0;
            mem_rdata = $urandom;
            if (rd_pend) begin
                if (rv_cnt == 0) begin
                    deliver = 1;
                    mem_rvalid = 1'b1;
                    mem_rdata = phys[rd_addr_m[9:2]];
                end else begin
                    rv_cnt--;
                end
            end
            if (mem_req) begin
                if (rdy_cnt == 0) mem_ready = 1'b1;
                else begin
                    mem_ready = 1'b0;
                    rdy_cnt--;
                end
            end else begin
                mem_ready = ($urandom_range(0, 3) == 0);
            end
            // CPU requester: one data op at a time, held until done
            if (!d_act) begin
                if (d_gap > 0) d_gap--;
                else if ($urandom_range(0, 2) == 0) begin
                    d_act = 1; d_st = 1'($urandom_range(0, 1));
                    d_a = {22'd0, 8'($urandom_range(64, 255)), 2'b00};
                    d_wd = $urandom; d_ws = 4'($urandom_range(1, 15)); d_age = 0;
                end
            end
            d_req = d_act; d_we = d_st; d_addr = d_a; d_wdata = d_wd; d_wstrb = d_ws;
            flush = ($urandom_range(0, 9) == 0);
            if (!f_act && $urandom_range(0, 1) == 0) begin
                f_act = 1; f_age = 0;
            end
            if_req = f_act; if_addr = f_a;
            to_sample();

            if (mem_req && mem_ready) begin
                if (mem_we) begin
                    check_eq("rnd_store_issue_pending", {63'd0, d_act && d_st}, 1);
                    check_eq("rnd_store_addr", mem_addr, d_a);
                    check_eq("rnd_store_wdata", mem_wdata, d_wd);
                    check_eq("rnd_store_wstrb", mem_wstrb, d_ws);
                    phys[mem_addr[9:2]] = merge(phys[mem_addr[9:2]], mem_wdata, mem_wstrb);
                end else begin
                    if (mem_addr >= 32'h100) begin
                        check_eq("rnd_load_issue_pending", {63'd0, d_act && !d_st}, 1);
                        check_eq("rnd_load_addr", mem_addr, d_a);
                    end
                    rd_pend = 1; rd_addr_m = mem_addr; rv_cnt = $urandom_range(0, 2);
                end
                rdy_cnt = $urandom_range(0, 2);
            end
            if (deliver) rd_pend = 0;

            if (d_done) begin
                check_eq("rnd_d_done_expected", d_done, {63'd0, d_act});
                if (d_act) begin
                    if (!d_st) begin
                        check_eq("rnd_load_data", d_rdata, ref_mem[d_a[9:2]]);
                        $display("tb: load  addr=0x%08h data=0x%08h", d_a, d_rdata);
                    end else begin
                        ref_mem[d_a[9:2]] = merge(ref_mem[d_a[9:2]], d_wd, d_ws);
                        $display("tb: store addr=0x%08h data=0x%08h strb=%b", d_a, d_wd, d_ws);
                    end
                    d_act = 0; d_gap = $urandom_range(1, 3);
                end
            end
            if (if_valid) begin
                check_eq("rnd_if_valid_expected", if_valid, {63'd0, f_act && !flush});
                if (f_act && !flush) begin
                    check_eq("rnd_fetch_data", if_rdata, ref_mem[f_a[9:2]]);
                    $display("tb: fetch addr=0x%08h data=0x%08h", f_a, if_rdata);
                    f_a = {24'd0, f_a[7:2] + 6'd1, 2'b00};
                    f_act = 1'($urandom_range(0, 1)); f_age = 0;
                end
            end
            if (flush) begin
                f_a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
                f_act = 1; f_age = 0;
            end
            if (d_act) begin
                d_age++;
                if (d_age > 80) begin
                    check_eq("rnd_data_timeout_age", d_age, 80);
                    abort = 1;
                end
            end
            if (f_act) begin
                f_age++;
                if (f_age > 80) begin
                    check_eq("rnd_fetch_timeout_age", f_age, 80);
                    abort = 1;
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
